// File: rtl/decoder_rr_arbiter.sv
// decoder_rr_arbiter: round-robin arbiter driving a 4-to-16 decoder select bus
// with break-before-make gaps and a bounded grant length.
module decoder_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    input  logic        done,
    output logic [3:0]  grant_idx,
    output logic        grant_en,
    output logic [15:0] grant_onehot,
    output logic        busy
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t      state_q, state_d;
    logic [3:0]  ptr_q, ptr_d, idx_q, idx_d, pick, j;
    logic [7:0]  hcnt_q, hcnt_d;
    logic        en_q, en_d, rel;
    logic [15:0] oh_q, oh_d;
    // Scan downward so the candidate closest to ptr wins last.
    always_comb begin
        pick = ptr_q;
        j    = ptr_q;
        for (int i = 15; i >= 0; i--) begin
            j = ptr_q + 4'(i);
            if (req[j]) pick = j;
        end
    end
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        hcnt_d  = hcnt_q;
        en_d    = en_q;
        oh_d    = oh_q;
        rel     = !req[idx_q] || done || (hcnt_q == 8'(MAX_HOLD - 1));
        if (state_q == IDLE) begin
            if (|req) begin
                state_d = GRANT;
                idx_d   = pick;
                en_d    = 1'b1;
                oh_d    = 16'h1 << pick;
                hcnt_d  = '0;
            end
        end else if (rel) begin
            state_d = IDLE;
            en_d    = 1'b0;
            oh_d    = '0;
            ptr_d   = idx_q + 4'd1;
        end else begin
            hcnt_d = hcnt_q + 8'd1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            hcnt_q  <= '0;
            en_q    <= 1'b0;
            oh_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            hcnt_q  <= hcnt_d;
            en_q    <= en_d;
            oh_q    <= oh_d;
        end
    end
    assign grant_idx    = idx_q;
    assign grant_en     = en_q;
    assign grant_onehot = oh_q;
    assign busy         = en_q;
endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// tb_decoder_rr_arbiter: directed checks of decoder_rr_arbiter at MAX_HOLD 8, 4 and 1.
module tb_decoder_rr_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] req8 = '0, req4 = '0, req1 = '0;
    logic        done8 = 1'b0;
    logic [3:0]  idx8, idx4, idx1;
    logic        en8, en4, en1, busy8, busy4, busy1;
    logic [15:0] oh8, oh4, oh1;
    int tests = 0;
    int fails = 0;

    decoder_rr_arbiter #(.MAX_HOLD(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .req(req8), .done(done8),
        .grant_idx(idx8), .grant_en(en8), .grant_onehot(oh8), .busy(busy8));
    decoder_rr_arbiter #(.MAX_HOLD(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req(req4), .done(1'b0),
        .grant_idx(idx4), .grant_en(en4), .grant_onehot(oh4), .busy(busy4));
    decoder_rr_arbiter #(.MAX_HOLD(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .done(1'b0),
        .grant_idx(idx1), .grant_en(en1), .grant_onehot(oh1), .busy(busy1));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #12;
        chk("rst_en", 16'(en8), 16'd0);
        chk("rst_idx", 16'(idx8), 16'd0);
        chk("rst_oh", oh8, 16'h0);
        chk("rst_busy", 16'(busy8), 16'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        // single requester, full-length grant then 1-cycle gap
        req8 = 16'h0020;
        tick();
        chk("single_idx", 16'(idx8), 16'd5);
        chk("single_oh", oh8, 16'h0020);
        chk("single_busy", 16'(busy8), 16'd1);
        for (int c = 1; c < 8; c++) begin
            tick();
            chk("single_hold", 16'(en8), 16'd1);
        end
        tick();
        chk("single_gap_en", 16'(en8), 16'd0);
        chk("single_gap_oh", oh8, 16'h0);
        chk("single_gap_idx", 16'(idx8), 16'd5);
        tick();
        chk("single_regrant_en", 16'(en8), 16'd1);
        chk("single_regrant_idx", 16'(idx8), 16'd5);
        req8 = 16'h0000;
        tick();
        chk("drop_release", 16'(en8), 16'd0);
        tick();
        chk("idle_stays", 16'(en8), 16'd0);
        // done on second grant cycle
        req8 = 16'h0040;
        tick();
        chk("done_grant_idx", 16'(idx8), 16'd6);
        tick();
        done8 = 1'b1;
        tick();
        done8 = 1'b0;
        chk("done_release", 16'(en8), 16'd0);
        req8 = 16'h0041;
        tick();
        chk("done_ptr_adv", 16'(idx8), 16'd0);
        chk("done_ptr_oh", oh8, 16'h0001);
        // req drop and done together advance ptr exactly once
        req8 = 16'h0040;
        done8 = 1'b1;
        tick();
        done8 = 1'b0;
        chk("dual_release", 16'(en8), 16'd0);
        req8 = 16'h0043;
        tick();
        chk("dual_next_idx", 16'(idx8), 16'd1);
        req8 = 16'h0000;
        tick();
        // no preemption
        req8 = 16'h0080;
        tick();
        chk("nopre_idx", 16'(idx8), 16'd7);
        req8 = 16'h0084;
        tick();
        chk("nopre_hold_idx", 16'(idx8), 16'd7);
        tick();
        chk("nopre_hold_oh", oh8, 16'h0080);
        req8 = 16'h0004;
        tick();
        chk("nopre_release", 16'(en8), 16'd0);
        chk("nopre_idx_kept", 16'(idx8), 16'd7);
        tick();
        chk("nopre_next_idx", 16'(idx8), 16'd2);
        chk("nopre_next_en", 16'(en8), 16'd1);
        req8 = 16'h0000;
        tick();
        // skip and wrap from ptr=14
        req8 = 16'h2000;
        tick();
        chk("wrap_first", 16'(idx8), 16'd13);
        req8 = 16'h0000;
        tick();
        req8 = 16'h0009;
        tick();
        chk("wrap_to0_idx", 16'(idx8), 16'd0);
        chk("wrap_to0_oh", oh8, 16'h0001);
        req8 = 16'h0008;
        tick();
        tick();
        chk("wrap_to3_idx", 16'(idx8), 16'd3);
        chk("wrap_to3_oh", oh8, 16'h0008);
        req8 = 16'h0000;
        tick();
        // asynchronous reset mid-grant
        req8 = 16'h0200;
        tick();
        chk("rstmid_grant", 16'(idx8), 16'd9);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_en", 16'(en8), 16'd0);
        chk("rstmid_idx", 16'(idx8), 16'd0);
        chk("rstmid_oh", oh8, 16'h0);
        chk("rstmid_busy", 16'(busy8), 16'd0);
        req8 = 16'h0201;
        tick();
        rst_n = 1'b1;
        tick();
        chk("rstmid_ptr0_idx", 16'(idx8), 16'd0);
        chk("rstmid_ptr0_en", 16'(en8), 16'd1);
        req8 = 16'h0000;
        // MAX_HOLD=1: one-cycle grants with one-cycle gaps
        req1 = 16'h0003;
        tick();
        chk("mh1_grant", 16'(en1), 16'd1);
        chk("mh1_idx0", 16'(idx1), 16'd0);
        tick();
        chk("mh1_gap", 16'(en1), 16'd0);
        tick();
        chk("mh1_idx1", 16'(idx1), 16'd1);
        chk("mh1_en1", 16'(en1), 16'd1);
        req1 = 16'h0000;
        tick();
        // full rotation at MAX_HOLD=4
        req4 = 16'hFFFF;
        for (int g = 0; g < 17; g++) begin
            for (int c = 0; c < 4; c++) begin
                tick();
                chk("rot_en", 16'(en4), 16'd1);
                chk("rot_idx", 16'(idx4), 16'(g % 16));
            end
            chk("rot_oh", oh4, 16'h1 << (g % 16));
            tick();
            chk("rot_gap", 16'(en4), 16'd0);
        end
        req4 = 16'h0000;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
